timer_cmp_bank: RTL
===================

# timer_cmp_bank

Parametrised bank of 64-bit timer compare channels on the core's memory-mapped peripheral bus. Each channel holds an atomically updated 64-bit compare value, a reload period, control bits and a sticky pending flag, and raises an interrupt when the free-running 64-bit timer count reaches its compare value. Channels are either one-shot or periodic; periodic channels auto-advance their compare value. The bank replaces the single fixed-address compare register pair and drives the core's timer interrupt lines.

## Interface
- NUM_CH, 2: number of compare channels, 1..8
- BASE_ADDR, 32'h2000_0100: address of channel 0, register 0
- CH_STRIDE, 32'h20: address distance between channels, power of two, at least 0x20

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- addr  in  32  bus byte address
- wdata  in  32  write data
- wr_en  in  1  write strobe, one cycle per write
- tcnt  in  64  current timer count, from the free-running counter
- rdata  out  32  read data for addr, combinational; 0 if addr unmapped
- irq  out  NUM_CH  per-channel interrupt, pend & IE
- irq_any  out  1  OR of irq
- tcmp  out  64*NUM_CH  committed compare values; channel k at bits [64k+63:64k]

## Operation
- Per-channel offsets: 0x00 CMP_LO, 0x04 CMP_HI, 0x08 PERIOD, 0x0C CTRL, 0x10 STATUS. Full 32-bit address decode; writes elsewhere ignored.
- CMP_LO write: loads shadow_lo only. Read returns committed cmp[31:0].
- CMP_HI write: commits cmp <= {wdata, shadow_lo} in one cycle and sets armed. Read returns cmp[63:32].
- PERIOD: 32-bit reload increment, R/W.
- CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; other bits write-ignored, read 0.
- STATUS: bit0 PEND, write 1 clears, write 0 no effect; bit1 ARMED, read-only.
- match_k = EN & armed & (tcnt >= cmp), unsigned 64-bit compare.
- On match: PEND <= 1. If PERIODIC: cmp <= cmp + {32'h0, PERIOD}, modulo 2^64, armed stays 1. Otherwise armed <= 0 and cmp is unchanged.
- PERIOD = 0 in periodic mode: cmp is unchanged, so the channel matches every cycle while EN=1 and tcnt >= cmp.
- Clearing EN stops new matches but keeps cmp, armed and PEND.
- irq_k = PEND_k & IE_k. It is level and stays asserted until PEND is cleared or IE is cleared.
- Reset values: cmp all channels 64'hFFFF_FFFF_FFFF_FFFF; shadow_lo 32'hFFFF_FFFF; PERIOD 0; CTRL 0; PEND 0; armed 0; irq 0; irq_any 0.
- Simultaneous events on one channel in one cycle:
  - W1C of PEND with a match: set wins, PEND stays 1.
  - CMP_HI write with a match: the write wins. cmp takes the written value, armed = 1, the match is discarded, and no PEND set or reload occurs.
  - CTRL write with a match: the match uses the pre-write CTRL value.
  - CMP_LO or PERIOD write with a match: the reload uses the pre-write PERIOD.
- Channels are fully independent. A write touches at most one register.

## Timing
- Matching is combinational from registered cmp/CTRL and the live tcnt. PEND, cmp reload and armed update at the same posedge.
- irq rises 1 cycle after the first cycle in which tcnt >= cmp. It rises 1 cycle after the CTRL write when IE is set with PEND already 1.
- A CMP_HI write takes effect at the write posedge. A match against the new value is possible on the following cycle.
- A periodic reload is visible on tcmp and in reads 1 cycle after the match.
- rdata has no latency and reflects register state before any write in the same cycle.
- rst_n assertion clears all state immediately, including mid-reload, and irq drops without waiting for a clock.

## Test plan
- Reset: check tcmp = all ones, rdata(STATUS) = 0 and irq = 0 with no writes. With tcnt at 2^64-1 and no CMP_HI write, no match occurs because armed = 0.
- One-shot, channel 0:
  - Stimulus: write LO = 0x100, HI = 0, CTRL = 0x5, then ramp tcnt.
  - Required: PEND and irq[0] rise the cycle after tcnt = 0x100, ARMED reads 0, and no further set occurs after W1C.
- Periodic reload across the 32-bit boundary:
  - Stimulus: cmp = 0x0000_0000_FFFF_FFF0, PERIOD = 0x20, CTRL = 0x7.
  - Required: after the match, cmp = 0x0000_0001_0000_0010. A 64-bit wrap from cmp = 2^64-0x10 gives 0x10.
- Atomic update: write LO = 0x50 while cmp = 0xFFFF…FF and tcnt = 0x60. Required: no match until HI = 0 is written; the match occurs the next cycle.
- Collisions, each in a single cycle:
  - W1C together with a match: PEND ends at 1.
  - CMP_HI write together with a match: PEND stays 0 and cmp equals the written value.
- Multi-channel with NUM_CH = 4:
  - Stimulus: channels 1 and 3 armed with distinct cmp values, IE on channel 3 only.
  - Required: irq = 4'b1000 and irq_any = 1, and PEND is set on both channels.
  - Then assert rst_n mid-run: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/timer_cmp_bank.sv
// timer_cmp_bank: bank of 64-bit timer compare channels with atomic update, periodic reload and sticky interrupts
module timer_cmp_bank #(
    parameter int          NUM_CH    = 2,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0100,
    parameter logic [31:0] CH_STRIDE = 32'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  wr_en,
    input  logic [63:0]           tcnt,
    output logic [31:0]           rdata,
    output logic [NUM_CH-1:0]     irq,
    output logic                  irq_any,
    output logic [64*NUM_CH-1:0]  tcmp
);
    localparam int SH = $clog2(CH_STRIDE);
    logic [31:0] off;
    logic [31:0] roff;
    logic        in_rng;
    logic [31:0] rd [NUM_CH];
    assign off    = addr - BASE_ADDR;
    assign roff   = off & (CH_STRIDE - 32'd1);
    assign in_rng = addr >= BASE_ADDR && off < 32'(NUM_CH) * CH_STRIDE;
    genvar k;
    for (k = 0; k < NUM_CH; k++) begin : g_ch
        logic [63:0] cmp;
        logic [31:0] shadow_lo;
        logic [31:0] period;
        logic [2:0]  ctrl;
        logic        pend;
        logic        armed;
        logic        sel;
        logic        match;
        logic        wr_lo, wr_hi, wr_per, wr_ctrl, wr_st;
        assign sel     = in_rng && (off >> SH) == 32'(k);
        assign wr_lo   = wr_en && sel && roff == 32'h00;
        assign wr_hi   = wr_en && sel && roff == 32'h04;
        assign wr_per  = wr_en && sel && roff == 32'h08;
        assign wr_ctrl = wr_en && sel && roff == 32'h0C;
        assign wr_st   = wr_en && sel && roff == 32'h10;
        assign match   = ctrl[0] && armed && tcnt >= cmp;
        // A CMP_HI write overrides a same-cycle match; a match overrides a same-cycle W1C.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmp       <= '1;
                shadow_lo <= '1;
                period    <= '0;
                ctrl      <= '0;
                pend      <= 1'b0;
                armed     <= 1'b0;
            end else begin
                if (wr_hi) begin
                    cmp   <= {wdata, shadow_lo};
                    armed <= 1'b1;
                end else if (match) begin
                    pend <= 1'b1;
                    if (ctrl[1])
                        cmp <= cmp + {32'h0, period};
                    else
                        armed <= 1'b0;
                end else if (wr_st && wdata[0]) begin
                    pend <= 1'b0;
                end
                if (wr_lo)
                    shadow_lo <= wdata;
                if (wr_per)
                    period <= wdata;
                if (wr_ctrl)
                    ctrl <= wdata[2:0];
            end
        end
        assign rd[k] = !sel             ? 32'h0 :
                       roff == 32'h00   ? cmp[31:0] :
                       roff == 32'h04   ? cmp[63:32] :
                       roff == 32'h08   ? period :
                       roff == 32'h0C   ? {29'h0, ctrl} :
                       roff == 32'h10   ? {30'h0, armed, pend} : 32'h0;
        assign irq[k]            = pend & ctrl[2];
        assign tcmp[64*k +: 64]  = cmp;
    end
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            rdata = rdata | rd[i];
    end
    assign irq_any = |irq;
endmodule
